// File: rtl/vga_char_sink.sv
// vga_char_sink: buffers CPU character writes in a FIFO and drains them into VRAM.
// Optional full-screen clear is enabled with the VGA_CLEAR_SCREEN_EN macro.
module vga_char_sink #(
    parameter int          DEPTH      = 8,
    parameter int          NUM_CELLS  = 1200,
    parameter int          ADDR_W     = 11,
    parameter logic [15:0] BLANK_CHAR = 16'h0000
) (
    input  logic                     wire_clock,
    input  logic                     wire_reset,
    input  logic                     videoflag,
    input  logic [15:0]              bus_vga_pos,
    input  logic [15:0]              bus_vga_char,
    input  logic                     scan_req,
`ifdef VGA_CLEAR_SCREEN_EN
    input  logic                     clear_req,
`endif
    output logic                     vram_we,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [15:0]              vram_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     range_err
);

    localparam int          PW   = $clog2(DEPTH);
    localparam int          EW   = ADDR_W + 16;
    localparam logic [16:0] NC17 = 17'(NUM_CELLS);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef VGA_CLEAR_SCREEN_EN
        S_CLEAR = 2'd2,
`endif
        S_DRAIN = 2'd1
    } state_t;

    state_t            state_q, state_d;
    logic [PW:0]       wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]     mem_q [DEPTH];
    logic              vram_we_q, vram_we_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [15:0]       vram_data_q, vram_data_d;
    logic              overflow_q, range_err_q;

    logic [PW:0]       count;
    logic              empty, full, in_range;
    logic              push, pop, drop_ovf, drop_rng;
    logic [EW-1:0]     rd_entry;
    logic              clr_start, clr_wr, clr_last;
    logic [ADDR_W-1:0] clr_addr;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (count == '0);
    assign full     = (count == FULL);
    assign in_range = ({1'b0, bus_vga_pos} < NC17);
    assign pop      = !empty && !scan_req && (state_q == S_DRAIN);
    assign push     = videoflag && in_range && (!full || pop);
    assign drop_ovf = videoflag && in_range && full && !pop;
    assign drop_rng = videoflag && !in_range;
    assign rd_entry = mem_q[rd_ptr_q[PW-1:0]];

`ifdef VGA_CLEAR_SCREEN_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CELLS - 1);
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    assign clr_start = clear_req && (state_q != S_CLEAR);
    assign clr_wr    = (state_q == S_CLEAR) && !scan_req;
    assign clr_last  = clr_wr && (clr_cnt_q == LAST);
    assign clr_addr  = clr_cnt_q;
    assign clr_cnt_d = clr_last ? '0 : (clr_wr ? clr_cnt_q + 1'b1 : clr_cnt_q);

    // Clear address sweep counter
    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) clr_cnt_q <= '0;
        else             clr_cnt_q <= clr_cnt_d;
    end
`else
    assign clr_start = 1'b0;
    assign clr_wr    = 1'b0;
    assign clr_last  = 1'b0;
    assign clr_addr  = '0;
`endif

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge wire_clock) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= {bus_vga_pos[ADDR_W-1:0], bus_vga_char};
    end

    // FIFO pointers and sticky error flags
    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (push)     wr_ptr_q    <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q    <= rd_ptr_q + 1'b1;
            if (drop_ovf) overflow_q  <= 1'b1;
            if (drop_rng) range_err_q <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic; IDLE leaves on the push itself to reach two-cycle latency
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start)           state_d = state_t'(2'd2);
                else if (!empty || push) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (clr_start)                              state_d = state_t'(2'd2);
                else if (pop && count == 1 && !push)        state_d = S_IDLE;
            end
`ifdef VGA_CLEAR_SCREEN_EN
            S_CLEAR: begin
                if (clr_last) state_d = (!empty || push) ? S_DRAIN : S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values: a pop or a clear write, otherwise hold address/data
    always_comb begin
        vram_we_d   = pop || clr_wr;
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        if (pop) begin
            vram_addr_d = rd_entry[EW-1:16];
            vram_data_d = rd_entry[15:0];
        end else if (clr_wr) begin
            vram_addr_d = clr_addr;
            vram_data_d = BLANK_CHAR;
        end
    end

    // Registered VRAM write port
    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) begin
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_data_q <= '0;
        end else begin
            vram_we_q   <= vram_we_d;
            vram_addr_q <= vram_addr_d;
            vram_data_q <= vram_data_d;
        end
    end

    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_data  = vram_data_q;
    assign fifo_count = count;
    assign busy       = full;
    assign overflow   = overflow_q;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_vga_char_sink.sv
// tb_vga_char_sink: scoreboard bench for vga_char_sink.
// Stimulus pushes expected VRAM writes; a negedge monitor retires them.
module tb_vga_char_sink;

`ifdef VGA_CLEAR_SCREEN_EN
    localparam int NC = 16;
`else
    localparam int NC = 1200;
`endif

    logic        clk, rst_n, vf, scan;
    logic [15:0] pos, ch;
    logic        we, busy, ovf, rerr;
    logic [10:0] addr;
    logic [15:0] data;
    logic [3:0]  cnt;
`ifdef VGA_CLEAR_SCREEN_EN
    logic        clr;
`endif

    int          checks = 0;
    int          failures = 0;
    int          writes = 0;
    logic        prev_scan = 1'b0;
    logic [26:0] exp_q [$];

    vga_char_sink #(.DEPTH(8), .NUM_CELLS(NC), .ADDR_W(11), .BLANK_CHAR(16'h0000)) dut (
        .wire_clock   (clk),
        .wire_reset   (rst_n),
        .videoflag    (vf),
        .bus_vga_pos  (pos),
        .bus_vga_char (ch),
        .scan_req     (scan),
`ifdef VGA_CLEAR_SCREEN_EN
        .clear_req    (clr),
`endif
        .vram_we      (we),
        .vram_addr    (addr),
        .vram_data    (data),
        .busy         (busy),
        .fifo_count   (cnt),
        .overflow     (ovf),
        .range_err    (rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) prev_scan = scan;

    // Monitor: every VRAM write must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && we) begin
            logic [26:0] e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL vram_unexpected actual=%h_%h required=no write", addr, data);
            end else begin
                e = exp_q.pop_front();
                if ({addr, data} !== e || prev_scan) begin
                    failures++;
                    $display("FAIL vram_write actual=%h_%h scan_prev=%0b required=%h_%h scan_prev=0",
                             addr, data, prev_scan, e[26:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [15:0] c, input bit acc);
        vf  = 1'b1;
        pos = 16'(p);
        ch  = c;
        if (acc) exp_q.push_back({pos[10:0], c});
        step();
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d left required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vf    = 1'b0;
        scan  = 1'b0;
`ifdef VGA_CLEAR_SCREEN_EN
        clr   = 1'b0;
`endif
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_rerr", 32'(rerr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst_n = 1'b1;
        vf    = 1'b0;
        scan  = 1'b0;
        pos   = '0;
        ch    = '0;
`ifdef VGA_CLEAR_SCREEN_EN
        clr   = 1'b0;
`endif
        #3;
        do_reset();

        // Single write, two-edge latency
        wr(5, 16'h0141, 1);
        vf = 1'b0;
        chk("lat_we_n1", 32'(we), 0);
        chk("lat_count_n1", 32'(cnt), 1);
        step();
        chk("lat_we_n2", 32'(we), 1);
        chk("lat_addr", 32'(addr), 5);
        chk("lat_data", 32'(data), 32'h0141);
        step();
        chk("lat_we_n3", 32'(we), 0);
        chk("lat_hold_addr", 32'(addr), 5);
        chk("lat_count_end", 32'(cnt), 0);

        // Overflow with scanner holding the port
        scan = 1'b1;
        for (int i = 0; i < 10; i++) wr(i, 16'h0200 + 16'(i), i < 8);
        vf = 1'b0;
        chk("ovf_busy", 32'(busy), 1);
        chk("ovf_count", 32'(cnt), 8);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_rerr", 32'(rerr), 0);
        scan = 1'b0;
        wait_drain(40);
        chk("ovf_count_end", 32'(cnt), 0);

        // Range boundary
        wr(NC, 16'h1234, 0);
        vf = 1'b0;
        chk("rng_flag", 32'(rerr), 1);
        chk("rng_count", 32'(cnt), 0);
        step();
        chk("rng_no_we", 32'(we), 0);
        wr(NC - 1, 16'h0777, 1);
        vf = 1'b0;
        wait_drain(20);

        // Scanner priority with alternating requests
        scan = 1'b1;
        for (int i = 0; i < 4; i++) wr(100 + i, 16'h0A00 + 16'(i), 1);
        vf = 1'b0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            scan = (k % 2 == 0);
            step();
        end
        scan = 1'b0;
        wait_drain(10);

        // Full FIFO with simultaneous pop across pointer wrap
        do_reset();
        for (int i = 0; i < 28; i++) begin
            scan = (i < 8);
            wr(300 + i, 16'h0C00 + 16'(i), 1);
        end
        vf = 1'b0;
        chk("wrap_count", 32'(cnt), 8);
        chk("wrap_no_ovf", 32'(ovf), 0);
        wait_drain(40);
        chk("wrap_count_end", 32'(cnt), 0);

`ifdef VGA_CLEAR_SCREEN_EN
        // Screen clear with a write queued mid-clear
        for (int i = 0; i < NC; i++) exp_q.push_back({11'(i), 16'h0000});
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (4) step();
        wr(3, 16'h00FF, 1);
        vf = 1'b0;
        wait_drain(60);
        chk("clr_count_end", 32'(cnt), 0);
`endif

        // Reset while draining
        scan = 1'b1;
        for (int i = 0; i < 3; i++) wr(40 + i, 16'h0E00 + 16'(i), 1);
        vf   = 1'b0;
        scan = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_we", 32'(we), 0);
        chk("mid_rst_addr", 32'(addr), 0);
        chk("mid_rst_count", 32'(cnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = writes;
        repeat (10) step();
        chk("post_rst_writes", 32'(writes - w0), 0);
        chk("post_rst_count", 32'(cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
